// File: rtl/tile_step_if.sv
// Handshake and board bus between the tile-game step controller and its
// environment (key inputs, wait timer, screen drawer).
interface tile_step_if;
    logic        start;
    logic [3:0]  key;
    logic        wait_done;
    logic        draw_done;
    logic        wait_go;
    logic        draw_req;
    logic [31:0] rows;
    logic [23:0] Q;
    logic        game_over;

    // Environment side: drives buttons, timer and drawer handshakes.
    modport master (
        output start, key, wait_done, draw_done,
        input  wait_go, draw_req, rows, Q, game_over
    );

    // Controller side.
    modport slave (
        input  start, key, wait_done, draw_done,
        output wait_go, draw_req, rows, Q, game_over
    );
endinterface

// File: rtl/tile_step_ctrl.sv
// Step controller for a four-lane falling-tile game.
// Each step reloads the wait timer, collects key presses while the timer runs,
// checks the captured keys against the bottom row, then scrolls the board and
// asks the drawer for a new frame. A wrong key set ends the game with the
// final board left on screen.
module tile_step_ctrl (
    input  logic        clk,
    input  logic        reset,
    tile_step_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int NUM_ROWS  = 8;
    localparam int ROWS_W    = NUM_LANES * NUM_ROWS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam logic [23:0] SCORE_MAX = 24'hFFFFFF;
    localparam logic [7:0]  LFSR_SEED = 8'h5A;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [ROWS_W-1:0]    rows;
    logic [23:0]          score;
    logic [NUM_LANES-1:0] mask;
    logic [NUM_LANES-1:0] key_q;
    logic [NUM_LANES-1:0] key_rise;
    logic [NUM_LANES-1:0] bottom;
    logic [NUM_LANES-1:0] new_row;
    logic [7:0]           lfsr;
    logic                 lfsr_fb;
    logic                 pass;

    // Per-lane rising-edge detect and new-row lane select.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign key_rise[l] = bus.key[l] & ~key_q[l];
        assign new_row[l]  = (lfsr[1:0] == 2'(l));
    end

    assign bottom  = rows[ROWS_W-1 -: NUM_LANES];
    assign pass    = (mask == bottom);
    // Taps 8,6,5,4 of an 8-bit Fibonacci LFSR.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Next-state decode; each wait state listens to exactly one handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT:  if (bus.wait_done) state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = pass ? S_DRAW : S_OVER;
            S_DRAW:  if (bus.draw_done) state_nxt = S_ARM;
            S_OVER:  if (bus.start) state_nxt = S_ARM;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, board, score, key capture and LFSR updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rows  <= '0;
            score <= '0;
            mask  <= '0;
            key_q <= '0;
            lfsr  <= LFSR_SEED;
        end else begin
            state <= state_nxt;
            key_q <= bus.key;
            case (state)
                S_IDLE, S_OVER: begin
                    if (bus.start) begin
                        rows  <= '0;
                        score <= '0;
                    end
                end
                S_ARM: mask <= '0;
                // Edges in the wait_done cycle still count; held keys do not.
                S_WAIT: mask <= mask | key_rise;
                S_SHIFT: begin
                    if (pass) begin
                        rows <= {rows[ROWS_W-NUM_LANES-1:0], new_row};
                        lfsr <= {lfsr[6:0], lfsr_fb};
                        // An empty bottom row matched by no keys scores nothing.
                        if (bottom != '0 && score != SCORE_MAX)
                            score <= score + 24'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes so reset drops them at once.
    assign bus.wait_go   = (state == S_WAIT);
    assign bus.draw_req  = (state == S_DRAW);
    assign bus.game_over = (state == S_OVER);
    assign bus.rows      = rows;
    assign bus.Q         = score;
endmodule
